// File: rtl/prog_counter.sv
// Up/down event counter with modulo limit, wrap/saturate boundary handling,
// enable prescaler, parallel load, terminal-count pulse and sticky overflow.
module prog_counter #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_ovf,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  ovf
);

  localparam logic [WIDTH-1:0]      CNT_ZERO = '0;
  localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PSC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] psc;
  logic                  tick;
  logic                  boundary;
  logic [WIDTH-1:0]      step_val;

  // Returns {boundary_event, next_value} for one count step in direction dir.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] lim,
                                                input logic             dir);
    logic [WIDTH:0] r;
    if (dir) begin
      if (cur < lim) r = {1'b0, cur + CNT_ONE};
      else           r = {1'b1, (SATURATE ? lim : CNT_ZERO)};
    end else begin
      // A count left above a lowered limit snaps back down without a boundary event.
      if (cur > lim)           r = {1'b0, lim};
      else if (cur == CNT_ZERO) r = {1'b1, (SATURATE ? CNT_ZERO : lim)};
      else                     r = {1'b0, cur - CNT_ONE};
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val,
                                                  input logic [WIDTH-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  assign tick = en && (psc == prescale);
  assign {boundary, step_val} = step_count(out, limit, up);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= '0;
      psc <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      out <= clamp_load(load_val, limit);
      psc <= '0;
      tc  <= 1'b0;
      ovf <= ovf & ~clr_ovf;
    end else begin
      if (en) psc <= tick ? '0 : psc + PSC_ONE;
      if (tick) out <= step_val;
      tc  <= tick & boundary;
      ovf <= (tick & boundary) | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: a wrap instance and a saturate instance
// share stimulus; a behavioural model queues expected outputs per cycle.
module tb_prog_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          up = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  limit = '1;
  logic [PW-1:0] prescale = '0;
  logic          clr_ovf = 1'b0;

  logic [W-1:0] out_w, out_s;
  logic         tc_w, tc_s, ovf_w, ovf_s;

  prog_counter #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .prescale(prescale), .clr_ovf(clr_ovf),
    .out(out_w), .tc(tc_w), .ovf(ovf_w));

  prog_counter #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .prescale(prescale), .clr_ovf(clr_ovf),
    .out(out_s), .tc(tc_s), .ovf(ovf_s));

  always #5 clk = ~clk;

  typedef struct {
    int o[2];
    int t[2];
    int v[2];
  } exp_t;

  exp_t exp_q[$];
  int   m_out[2], m_psc[2], m_tc[2], m_ovf[2];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  // Advance the reference model by one edge using the currently driven inputs.
  task automatic model_edge();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      int  lim;
      int  bnd;
      bit  tk;
      lim = int'(limit);
      bnd = 0;
      tk  = 1'b0;
      if (!rst) begin
        m_out[i] = 0; m_psc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_out[i] = (int'(load_val) > lim) ? lim : int'(load_val);
        m_psc[i] = 0;
        m_tc[i]  = 0;
        if (clr_ovf) m_ovf[i] = 0;
      end else begin
        if (en) begin
          if (m_psc[i] == int'(prescale)) begin
            tk = 1'b1;
            m_psc[i] = 0;
          end else begin
            m_psc[i] = (m_psc[i] + 1) % (1 << PW);
          end
        end
        if (tk) begin
          if (up) begin
            if (m_out[i] >= lim) begin
              bnd = 1;
              m_out[i] = (i == 1) ? lim : 0;
            end else m_out[i] = m_out[i] + 1;
          end else begin
            if (m_out[i] > lim) m_out[i] = lim;
            else if (m_out[i] == 0) begin
              bnd = 1;
              m_out[i] = (i == 1) ? 0 : lim;
            end else m_out[i] = m_out[i] - 1;
          end
        end
        m_tc[i] = bnd;
        if (clr_ovf) m_ovf[i] = 0;
        if (bnd != 0) m_ovf[i] = 1;
      end
      e.o[i] = m_out[i];
      e.t[i] = m_tc[i];
      e.v[i] = m_ovf[i];
    end
    exp_q.push_back(e);
  endtask

  // Push expectation, clock one edge, then pop and compare away from the edge.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("wrap_out", 32'(out_w), 32'(e.o[0]));
      chk("wrap_tc",  32'(tc_w),  32'(e.t[0]));
      chk("wrap_ovf", 32'(ovf_w), 32'(e.v[0]));
      chk("sat_out",  32'(out_s), 32'(e.o[1]));
      chk("sat_tc",   32'(tc_s),  32'(e.t[1]));
      chk("sat_ovf",  32'(ovf_s), 32'(e.v[1]));
    end
  endtask

  task automatic do_load(input logic [W-1:0] val, input logic [W-1:0] lim);
    load = 1'b1; load_val = val; limit = lim;
    step();
    load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_psc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end

    // Reset state
    rst = 1'b0;
    step();
    chk("reset_out", 32'(out_w), 32'd0);
    rst = 1'b1;

    // Reset mid-count, then a low pulse between edges must be ignored
    limit = 8'd20; en = 1'b1; up = 1'b1;
    repeat (6) step();
    rst = 1'b0;
    step();
    chk("midreset_out", 32'(out_w), 32'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("glitch_rst_out", 32'(out_w), 32'd1);

    // Wrap up from 0 with limit 5
    en = 1'b0; clr_ovf = 1'b1;
    do_load(8'd0, 8'd5);
    clr_ovf = 1'b0; en = 1'b1; up = 1'b1;
    repeat (6) step();
    chk("wrap_end_out", 32'(out_w), 32'd0);
    chk("wrap_end_tc",  32'(tc_w),  32'd1);
    step();
    chk("wrap_ovf_sticky", 32'(ovf_w), 32'd1);
    chk("wrap_tc_single", 32'(tc_w), 32'd0);

    // Prescale by 3, then hold with en low
    prescale = 4'd2;
    do_load(8'd0, 8'd100);
    en = 1'b1;
    repeat (9) step();
    chk("presc_out", 32'(out_w), 32'd3);
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    step();
    chk("presc_resume_out", 32'(out_w), 32'd3);

    // Saturating count down; clear colliding with a boundary tick
    prescale = 4'd0; en = 1'b0;
    do_load(8'd2, 8'd10);
    en = 1'b1; up = 1'b0;
    repeat (3) step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("satdn_out", 32'(out_s), 32'd0);
    chk("satdn_tc",  32'(tc_s),  32'd1);
    chk("satdn_ovf_setwins", 32'(ovf_s), 32'd1);

    // Load clamp with en high, then load under reset
    en = 1'b1; up = 1'b1;
    do_load(8'd50, 8'd10);
    chk("load_clamp_out", 32'(out_w), 32'd10);
    rst = 1'b0;
    do_load(8'd7, 8'd10);
    rst = 1'b1;
    chk("load_rst_out", 32'(out_w), 32'd0);

    // Limit shrink below the current count, up then down
    en = 1'b0;
    do_load(8'd8, 8'd10);
    limit = 8'd3; en = 1'b1; up = 1'b1;
    step();
    chk("shrink_up_out", 32'(out_w), 32'd0);
    chk("shrink_up_tc",  32'(tc_w),  32'd1);
    en = 1'b0;
    do_load(8'd8, 8'd10);
    limit = 8'd3; en = 1'b1; up = 1'b0;
    step();
    chk("shrink_dn_out", 32'(out_w), 32'd3);
    chk("shrink_dn_tc",  32'(tc_w),  32'd0);

    // limit 0: every tick is a boundary event
    limit = 8'd0; up = 1'b1;
    repeat (3) step();
    chk("lim0_tc", 32'(tc_w), 32'd1);

    // Prescale lowered below the running prescaler count
    prescale = 4'd9; limit = 8'd200;
    repeat (5) step();
    prescale = 4'd1;
    repeat (20) step();

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      rst      = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      clr_ovf  = ($urandom_range(0, 7) == 0);
      load_val = 8'($urandom_range(0, 255));
      limit    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                             : 8'($urandom_range(0, 40));
      prescale = 4'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
